// File: rtl/inst_mem_resp.sv
// Instruction-memory responder: combinational fetch port plus a byte-stream
// loader that fills the memory from a host while holding the core in reset.
module inst_mem_resp #(
  parameter int          ADDR_W   = 12,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       inst_addr_i,
  output logic [31:0]       inst_o,
  input  logic              load_start_i,
  input  logic              load_valid_i,
  input  logic [7:0]        load_byte_i,
  input  logic              load_last_i,
  output logic              load_ready_o,
  output logic              load_done_o,
  output logic              core_rst_o,
  output logic [ADDR_W:0]   load_cnt_o,
  output logic              ovf_o,
  output logic [1:0]        dbg_state_o
);

  // Host handshake: a byte moves on every rising edge where load_valid_i and
  // load_ready_o are both 1; with load_ready_o=0 the host keeps the byte.

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]       asm_q, asm_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              ovf_q, ovf_d;

  logic [31:0]       mem [DEPTH];
  logic [31:0]       merged;
  logic              word_req;
  logic [31:0]       word_data;
  logic              mem_we;
  logic              mem_full;

  assign mem_full = cnt_q[ADDR_W];

  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    wr_ptr_d   = wr_ptr_q;
    asm_d      = asm_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    word_req   = 1'b0;
    word_data  = asm_q;
    mem_we     = 1'b0;
    merged     = asm_q;
    merged[{byte_idx_q, 3'b000} +: 8] = load_byte_i;

    case (state_q)
      S_IDLE: begin
        if (load_start_i) begin
          wr_ptr_d   = '0;
          byte_idx_d = '0;
          asm_d      = '0;
          cnt_d      = '0;
          ovf_d      = 1'b0;
          state_d    = S_LOAD;
        end
      end
      S_LOAD: begin
        if (load_valid_i) begin
          if (byte_idx_q == 2'd3) begin
            word_req   = 1'b1;
            word_data  = merged;
            byte_idx_d = '0;
            asm_d      = '0;
            if (load_last_i) state_d = S_DONE;
          end else begin
            asm_d      = merged;
            byte_idx_d = byte_idx_q + 2'd1;
            if (load_last_i) state_d = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        // Unfilled upper lanes of the tail word are already zero in asm_q.
        word_req   = 1'b1;
        word_data  = asm_q;
        asm_d      = '0;
        byte_idx_d = '0;
        state_d    = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (word_req) begin
      if (mem_full) begin
        ovf_d = 1'b1;
      end else begin
        mem_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + PTR_ONE;
        cnt_d    = cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      byte_idx_q <= '0;
      wr_ptr_q   <= '0;
      asm_q      <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      wr_ptr_q   <= wr_ptr_d;
      asm_q      <= asm_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  // Memory contents survive reset so a loaded image outlives a core restart.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr_q] <= word_data;
  end

  logic unused_addr_bits;
  assign unused_addr_bits = ^{inst_addr_i[31:ADDR_W+2], inst_addr_i[1:0]};

  assign core_rst_o   = (state_q != S_IDLE);
  assign load_ready_o = (state_q == S_LOAD);
  assign load_done_o  = (state_q == S_DONE);
  assign load_cnt_o   = cnt_q;
  assign ovf_o        = ovf_q;
  assign dbg_state_o  = state_q;
  assign inst_o       = core_rst_o ? NOP_INST : mem[inst_addr_i[ADDR_W+1:2]];

endmodule

// File: tb/tb_inst_mem_resp.sv
// Bench for inst_mem_resp: randomized load sessions and fetches checked by a
// queue scoreboard against a word-list model of the loaded image.
module tb_inst_mem_resp;

  localparam int AW = 3;
  localparam int DEPTH = 1 << AW;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   inst_addr_i = '0;
  logic [31:0]   inst_o;
  logic          load_start_i = 1'b0;
  logic          load_valid_i = 1'b0;
  logic [7:0]    load_byte_i = '0;
  logic          load_last_i = 1'b0;
  logic          load_ready_o;
  logic          load_done_o;
  logic          core_rst_o;
  logic [AW:0]   load_cnt_o;
  logic          ovf_o;
  logic [1:0]    dbg_state_o;

  inst_mem_resp #(.ADDR_W(AW), .NOP_INST(NOP)) dut (
    .clk          (clk),
    .rst          (rst),
    .inst_addr_i  (inst_addr_i),
    .inst_o       (inst_o),
    .load_start_i (load_start_i),
    .load_valid_i (load_valid_i),
    .load_byte_i  (load_byte_i),
    .load_last_i  (load_last_i),
    .load_ready_o (load_ready_o),
    .load_done_o  (load_done_o),
    .core_rst_o   (core_rst_o),
    .load_cnt_o   (load_cnt_o),
    .ovf_o        (ovf_o),
    .dbg_state_o  (dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int vectors = 0;
  int errs = 0;
  int done_seen = 0;
  int sessions = 0;
  logic [31:0]   model_mem [DEPTH];
  logic [31:0]   rd_q[$];
  logic [AW+1:0] done_q[$];
  logic          rd_chk = 1'b0;
  logic [31:0]   e_rd;
  logic [AW+1:0] e_dn;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    return model_mem[(a >> 2) % DEPTH];
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rd_chk) begin
      if (rd_q.size() == 0) begin
        vectors++; errs++;
        $display("FAIL rd_q_empty: fetch check with no expected value");
      end else begin
        e_rd = rd_q.pop_front();
        chk("inst_o", inst_o, e_rd);
      end
    end
    if (load_done_o) begin
      done_seen++;
      if (done_q.size() == 0) begin
        vectors++; errs++;
        $display("FAIL unexpected_done: load_done_o=1 with no session pending");
      end else begin
        e_dn = done_q.pop_front();
        chk("done_load_cnt", 32'(load_cnt_o), 32'(e_dn[AW+1:1]));
        chk("done_ovf", 32'(ovf_o), 32'(e_dn[0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_read(input logic [31:0] addr);
    inst_addr_i = addr;
    rd_chk = 1'b1;
    rd_q.push_back(model_rd(addr));
    chk("core_rst_idle_read", 32'(core_rst_o), 32'd0);
    @(posedge clk); #1;
    rd_chk = 1'b0;
  endtask

  task automatic loading_cycle_checks();
    inst_addr_i = $urandom;
    rd_chk = 1'b1;
    rd_q.push_back(NOP);
    chk("ready_in_load", 32'(load_ready_o), 32'd1);
    chk("core_rst_in_load", 32'(core_rst_o), 32'd1);
  endtask

  task automatic do_load(input logic [7:0] b[$], input int min_gap, input int max_gap);
    int n;
    int nw;
    int lat;
    logic [AW:0]  ec;
    logic         eo;
    logic [31:0]  w;
    n  = b.size();
    nw = (n + 3) / 4;
    ec = (AW+1)'((nw < DEPTH) ? nw : DEPTH);
    eo = (nw > DEPTH);
    load_start_i = 1'b1;
    @(posedge clk); #1;
    load_start_i = 1'b0;
    chk("start_cnt_cleared", 32'(load_cnt_o), 32'd0);
    chk("start_ovf_cleared", 32'(ovf_o), 32'd0);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(min_gap, max_gap)) begin
        load_valid_i = 1'b0;
        load_byte_i  = 8'($urandom);
        load_last_i  = 1'($urandom);
        load_start_i = ($urandom_range(0, 3) == 0);
        loading_cycle_checks();
        @(posedge clk); #1;
      end
      load_start_i = 1'b0;
      load_valid_i = 1'b1;
      load_byte_i  = b[i];
      load_last_i  = (i == n - 1);
      loading_cycle_checks();
      chk("no_done_in_load", 32'(load_done_o), 32'd0);
      if (i == n - 1) begin
        done_q.push_back({ec, eo});
        sessions++;
      end
      @(posedge clk); #1;
    end
    load_valid_i = 1'b0;
    load_last_i  = 1'b0;
    rd_chk = 1'b0;
    lat = 0;
    while (!load_done_o && lat < 8) begin
      chk("core_rst_in_flush", 32'(core_rst_o), 32'd1);
      chk("ready_low_in_flush", 32'(load_ready_o), 32'd0);
      @(posedge clk); #1;
      lat++;
    end
    chk("done_latency", lat, (n % 4 == 0) ? 32'd0 : 32'd1);
    chk("core_rst_in_done", 32'(core_rst_o), 32'd1);
    chk("ready_low_in_done", 32'(load_ready_o), 32'd0);
    @(posedge clk); #1;
    chk("core_rst_dropped", 32'(core_rst_o), 32'd0);
    chk("done_single_pulse", 32'(load_done_o), 32'd0);
    for (int k = 0; k < nw && k < DEPTH; k++) begin
      w = '0;
      for (int j = 0; j < 4; j++)
        if (4 * k + j < n) w[8*j +: 8] = b[4*k + j];
      model_mem[k] = w;
    end
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] bq[$];

  initial begin
    #2;
    chk("rst_ready", 32'(load_ready_o), 32'd0);
    chk("rst_done", 32'(load_done_o), 32'd0);
    chk("rst_core_rst", 32'(core_rst_o), 32'd0);
    chk("rst_cnt", 32'(load_cnt_o), 32'd0);
    chk("rst_ovf", 32'(ovf_o), 32'd0);
    #21 rst = 1'b0;
    @(posedge clk); #1;

    // Bytes offered in IDLE must not be consumed.
    load_valid_i = 1'b1;
    load_byte_i  = 8'hAA;
    repeat (2) begin
      chk("idle_ready_low", 32'(load_ready_o), 32'd0);
      @(posedge clk); #1;
    end
    load_valid_i = 1'b0;

    // Fill the whole memory so every fetch has a known expected value.
    bq = {};
    for (int i = 0; i < 4 * DEPTH; i++) bq.push_back(8'($urandom));
    do_load(bq, 0, 0);
    for (int i = 0; i < 8; i++) do_read($urandom);

    // Word 1 = DEADBEEF; fetch at 4 and at 7 (low bits ignored).
    bq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    do_load(bq, 0, 0);
    chk("model_word1", model_rd(32'h4), 32'hDEAD_BEEF);
    do_read(32'h4);
    do_read(32'h7);

    // Single word, back-to-back.
    bq = '{8'h13, 8'h05, 8'hA0, 8'h00};
    do_load(bq, 0, 0);
    do_read(32'h0);
    do_read(32'(DEPTH * 4));

    // Partial tail goes through FLUSH.
    bq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    do_load(bq, 0, 1);
    do_read(32'h0);
    do_read(32'h5);

    // Same single word with two idle cycles between bytes.
    bq = '{8'h13, 8'h05, 8'hA0, 8'h00};
    do_load(bq, 2, 2);
    do_read(32'h3);
    do_read(32'h4);

    // Overflow: more than DEPTH words, ending on a partial word.
    bq = {};
    for (int i = 0; i < 4 * DEPTH + 6; i++) bq.push_back(8'($urandom));
    do_load(bq, 0, 1);
    for (int i = 0; i < DEPTH; i++) do_read(32'(4 * i + $urandom_range(0, 3)));

    // Random sessions.
    for (int s = 0; s < 12; s++) begin
      bq = {};
      for (int i = 0; i < int'($urandom_range(1, 4 * DEPTH + 8)); i++)
        bq.push_back(8'($urandom));
      do_load(bq, 0, 2);
      for (int i = 0; i < 6; i++) do_read($urandom);
    end

    // Asynchronous reset two bytes into the second word.
    bq = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6};
    load_start_i = 1'b1;
    @(posedge clk); #1;
    load_start_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      load_valid_i = 1'b1;
      load_byte_i  = bq[i];
      @(posedge clk); #1;
    end
    load_valid_i = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_core_rst", 32'(core_rst_o), 32'd0);
    chk("arst_ready", 32'(load_ready_o), 32'd0);
    chk("arst_cnt", 32'(load_cnt_o), 32'd0);
    chk("arst_ovf", 32'(ovf_o), 32'd0);
    @(posedge clk); #3 rst = 1'b0;
    @(posedge clk); #1;
    model_mem[0] = 32'hC4C3_C2C1;
    do_read(32'h0);
    do_read(32'h4);
    do_read(32'h8);

    repeat (3) @(posedge clk);
    #1;
    chk("done_pulse_count", done_seen, sessions);
    chk("done_q_drained", done_q.size(), 32'd0);
    chk("rd_q_drained", rd_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
